ahb_apb_bridge_p: RTL and testbench

Parametrised AHB-to-APB bridge: a single AHB slave port drives NSLV APB4 slaves behind one address window. Adds PREADY wait states, PSLVERR propagation, PSTRB generation, an alignment/decode error check and an access timeout, with a two-cycle AHB ERROR response. Sits between the AHB decoder (HSEL) and the APB peripheral cluster; one transfer is in flight at a time.

---
 rtl/ahb_apb_bridge_p.sv | 229 ++++++++++++++++++++++
 tb/tb_ahb_apb_bridge_p.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge_p.sv
// AHB-to-APB4 bridge: one AHB slave port fanned out to NSLV APB slaves in one address window.
// One transfer in flight; PREADY waits, PSLVERR/decode/alignment errors and an access timeout.
module ahb_apb_bridge_p #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned DEC_LSB = 12,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [DATA_W-1:0]      HWDATA,
    input  logic                   HREADYin,
    output logic [DATA_W-1:0]      HRDATA,
    output logic                   HREADYout,
    output logic [1:0]             HRESP,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    output logic [DATA_W/8-1:0]    PSTRB,
    output logic                   PWRITE,
    output logic [NSLV-1:0]        PSEL,
    output logic                   PENABLE,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);

    localparam int unsigned SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(STRB_W);
    // The whole 4-bit index field is range-checked so aliases beyond NSLV fault.
    localparam int unsigned DEC_W  = (DEC_LSB + 4 <= ADDR_W) ? 4 : ADDR_W - DEC_LSB;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic [SEL_W-1:0]    idx_q;
    logic [DEC_W-1:0]    dec_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DATA_W-1:0]   hrdata_q;
    logic                hready_q;
    logic [1:0]          hresp_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic                pwrite_q;
    logic [NSLV-1:0]     psel_q;
    logic                penable_q;

    logic                lat_err;
    logic [STRB_W-1:0]   pstrb_d;
    logic [NSLV-1:0]     psel_d;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                accept;
    logic                unused_htrans;

    assign unused_htrans = HTRANS[0];
    assign accept        = HSEL & HREADYin & HTRANS[1];

    // Decode, size and alignment check on the latched address phase.
    always_comb begin
        lat_err = 1'b0;
        if (32'(dec_q) >= NSLV) begin
            lat_err = 1'b1;
        end
        if (32'(size_q) > LANE_W) begin
            lat_err = 1'b1;
        end else begin
            for (int i = 0; i < int'(LANE_W); i++) begin
                if ((i < int'(size_q)) && addr_q[i]) begin
                    lat_err = 1'b1;
                end
            end
        end
    end

    // Byte lanes covered by an aligned transfer of 2**size bytes.
    always_comb begin
        pstrb_d = '0;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if ((i >> size_q) == (int'(addr_q[LANE_W-1:0]) >> size_q)) begin
                pstrb_d[i] = 1'b1;
            end
        end
        if (!write_q) begin
            pstrb_d = '0;
        end
    end

    always_comb begin
        psel_d    = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (idx_q == SEL_W'(i)) begin
                psel_d[i] = 1'b1;
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            idx_q     <= '0;
            dec_q     <= '0;
            cnt_q     <= '0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= 2'b00;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    hready_q <= 1'b1;
                    hresp_q  <= 2'b00;
                    if (accept) begin
                        addr_q   <= HADDR;
                        write_q  <= HWRITE;
                        size_q   <= HSIZE;
                        idx_q    <= HADDR[DEC_LSB +: SEL_W];
                        dec_q    <= HADDR[DEC_LSB +: DEC_W];
                        hready_q <= 1'b0;
                        state_q  <= StLatch;
                    end
                end
                StLatch: begin
                    if (lat_err) begin
                        hresp_q <= 2'b01;
                        state_q <= StErr1;
                    end else begin
                        psel_q   <= psel_d;
                        paddr_q  <= addr_q;
                        pwrite_q <= write_q;
                        pstrb_q  <= pstrb_d;
                        if (write_q) begin
                            pwdata_q <= HWDATA;
                        end
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (sel_ready) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        if (sel_err) begin
                            hresp_q <= 2'b01;
                            state_q <= StErr1;
                        end else begin
                            if (!write_q) begin
                                hrdata_q <= sel_rdata;
                            end
                            hready_q <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        hresp_q   <= 2'b01;
                        state_q   <= StErr1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StErr1: begin
                    hready_q <= 1'b1;
                    state_q  <= StErr2;
                end
                StErr2: begin
                    hresp_q <= 2'b00;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYout = hready_q;
    assign HRESP     = hresp_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_ahb_apb_bridge_p.sv
// Bench for ahb_apb_bridge_p: vector table with an expectation queue, plus timeout/reset sequences.
// Two instances share stimulus: TIMEOUT=8 (main) and TIMEOUT=0 (never times out).
module tb_ahb_apb_bridge_p;

    logic         clk = 1'b0;
    logic         hreset;
    logic         hsel;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [31:0]  hwdata;
    logic         hreadyin;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    logic [31:0]  hrdata, hrdata_z;
    logic         hreadyout, hreadyout_z;
    logic [1:0]   hresp, hresp_z;
    logic [31:0]  paddr, paddr_z;
    logic [31:0]  pwdata, pwdata_z;
    logic [3:0]   pstrb, pstrb_z;
    logic         pwrite, pwrite_z;
    logic [3:0]   psel, psel_z;
    logic         penable, penable_z;

    always #5 clk = ~clk;

    ahb_apb_bridge_p #(.ADDR_W(32), .DATA_W(32), .NSLV(4), .DEC_LSB(12), .TIMEOUT(8)) u_dut (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADYin(hreadyin),
        .HRDATA(hrdata), .HREADYout(hreadyout), .HRESP(hresp), .PADDR(paddr),
        .PWDATA(pwdata), .PSTRB(pstrb), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    ahb_apb_bridge_p #(.ADDR_W(32), .DATA_W(32), .NSLV(4), .DEC_LSB(12), .TIMEOUT(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADYin(hreadyin),
        .HRDATA(hrdata_z), .HREADYout(hreadyout_z), .HRESP(hresp_z), .PADDR(paddr_z),
        .PWDATA(pwdata_z), .PSTRB(pstrb_z), .PWRITE(pwrite_z), .PSEL(psel_z),
        .PENABLE(penable_z), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        bit          slverr;
        logic [1:0]  e_resp;
        int          e_low;
        logic [3:0]  e_psel;
        int          e_pcyc;
        logic [3:0]  e_strb;
        logic [31:0] e_hrdata;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[13];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge where the bridge is idle and ready; returns at a negedge likewise.
    task automatic run_xfer(input int k, input vec_t v);
        vec_t        e;
        int          idx, acc, low, pcyc;
        bit          done, onehot_ok;
        logic [3:0]  psel_seen, strb_seen;
        logic [31:0] paddr_seen, pwdata_seen;
        logic        pwrite_seen;
        exp_q.push_back(v);
        idx = int'((v.addr >> 12) & 32'h3);
        acc = 0; low = 0; pcyc = 0; done = 0; onehot_ok = 1;
        psel_seen = '0; strb_seen = '0; paddr_seen = '0; pwdata_seen = '0; pwrite_seen = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.write; hsize = v.size;
        hreadyin = 1'b1;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            pready  = ~(4'b0001 << idx);
            pslverr = 4'b0000;
            prdata  = '1;
            if ($countones(psel) > 1) onehot_ok = 0;
            if (hreadyout) begin
                done = 1;
            end else begin
                low++;
                if (psel != 4'b0000) begin
                    pcyc++;
                    psel_seen = psel_seen | psel;
                    if (!penable) begin
                        strb_seen = pstrb; paddr_seen = paddr;
                        pwdata_seen = pwdata; pwrite_seen = pwrite;
                    end else begin
                        acc++;
                        prdata[idx*32 +: 32] = v.rdata;
                        if (acc > v.waits) begin
                            pready[idx]  = 1'b1;
                            pslverr[idx] = v.slverr;
                        end
                    end
                end
                @(negedge clk);
            end
        end
        pready = 4'b0000; pslverr = 4'b0000;
        e = exp_q.pop_front();
        check($sformatf("v%0d done", k), 32'(done), 1);
        check($sformatf("v%0d hresp", k), 32'(hresp), 32'(e.e_resp));
        check($sformatf("v%0d low cycles", k), low, e.e_low);
        check($sformatf("v%0d psel", k), 32'(psel_seen), 32'(e.e_psel));
        check($sformatf("v%0d psel cycles", k), pcyc, e.e_pcyc);
        check($sformatf("v%0d onehot", k), 32'(onehot_ok), 1);
        check($sformatf("v%0d hrdata", k), hrdata, e.e_hrdata);
        if (e.e_psel != 4'b0000) begin
            check($sformatf("v%0d pstrb", k), 32'(strb_seen), 32'(e.e_strb));
            check($sformatf("v%0d paddr", k), paddr_seen, e.addr);
            check($sformatf("v%0d pwrite", k), 32'(pwrite_seen), 32'(e.write));
            if (e.write) check($sformatf("v%0d pwdata", k), pwdata_seen, e.wdata);
        end
        if (e.e_resp == 2'b01) begin
            @(negedge clk);
            check($sformatf("v%0d hresp clear", k), 32'(hresp), 0);
            check($sformatf("v%0d ready after err", k), 32'(hreadyout), 1);
        end
    endtask

    initial begin
        int  low, pcyc;
        bit  got;
        logic [1:0] resp;
        vec_t fin;

        hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; hreadyin = 1'b1; prdata = '0; pready = '0; pslverr = '0;

        //         wr    addr          sz    wdata          rdata          wt sl  resp  low psel     pc strb     hrdata
        tbl[0]  = '{1'b1, 32'h0000_1004, 3'd2, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 2'b00, 3, 4'b0010, 2, 4'b1111, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_3000, 3'd2, 32'h0,         32'h1234_5678, 2, 1'b0, 2'b00, 5, 4'b1000, 4, 4'b0000, 32'h1234_5678};
        tbl[2]  = '{1'b1, 32'h0000_0002, 3'd0, 32'h00A5_0000, 32'h0,         0, 1'b0, 2'b00, 3, 4'b0001, 2, 4'b0100, 32'h1234_5678};
        tbl[3]  = '{1'b1, 32'h0000_0001, 3'd1, 32'h1111_1111, 32'h0,         0, 1'b0, 2'b01, 2, 4'b0000, 0, 4'b0000, 32'h1234_5678};
        tbl[4]  = '{1'b0, 32'h0000_5000, 3'd2, 32'h0,         32'h0,         0, 1'b0, 2'b01, 2, 4'b0000, 0, 4'b0000, 32'h1234_5678};
        tbl[5]  = '{1'b0, 32'h0000_2000, 3'd2, 32'h0,         32'hAAAA_5555, 0, 1'b1, 2'b01, 4, 4'b0100, 2, 4'b0000, 32'h1234_5678};
        tbl[6]  = '{1'b1, 32'h0000_2006, 3'd1, 32'hBEEF_0000, 32'h0,         0, 1'b0, 2'b00, 3, 4'b0100, 2, 4'b1100, 32'h1234_5678};
        tbl[7]  = '{1'b0, 32'h0000_1008, 3'd2, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 2'b00, 4, 4'b0010, 3, 4'b0000, 32'hCAFE_F00D};
        tbl[8]  = '{1'b1, 32'h0000_0000, 3'd3, 32'h2222_2222, 32'h0,         0, 1'b0, 2'b01, 2, 4'b0000, 0, 4'b0000, 32'hCAFE_F00D};
        tbl[9]  = '{1'b1, 32'h0000_3003, 3'd0, 32'h7700_0000, 32'h0,         0, 1'b0, 2'b00, 3, 4'b1000, 2, 4'b1000, 32'hCAFE_F00D};
        tbl[10] = '{1'b1, 32'h0000_0002, 3'd2, 32'h3333_3333, 32'h0,         0, 1'b0, 2'b01, 2, 4'b0000, 0, 4'b0000, 32'hCAFE_F00D};
        tbl[11] = '{1'b0, 32'h0000_1000, 3'd2, 32'h0,         32'h0BAD_F00D, 3, 1'b1, 2'b01, 7, 4'b0010, 5, 4'b0000, 32'hCAFE_F00D};
        tbl[12] = '{1'b0, 32'h0000_0004, 3'd1, 32'h0,         32'h55AA_33CC, 0, 1'b0, 2'b00, 3, 4'b0001, 2, 4'b0000, 32'h55AA_33CC};

        repeat (3) @(negedge clk);
        check("rst hreadyout", 32'(hreadyout), 1);
        check("rst hresp", 32'(hresp), 0);
        check("rst hrdata", hrdata, 0);
        check("rst psel", 32'(psel), 0);
        check("rst penable", 32'(penable), 0);
        check("rst pwrite", 32'(pwrite), 0);
        check("rst paddr", paddr, 0);
        check("rst pwdata", pwdata, 0);
        check("rst pstrb", 32'(pstrb), 0);
        hreset = 1'b0;
        @(negedge clk);

        // Non-accepting address phases give zero-wait OKAY.
        hsel = 1'b1; htrans = 2'b00; haddr = 32'h0000_1000;
        @(negedge clk);
        check("idle trans ready", 32'({hreadyout, hresp, psel}), 32'({1'b1, 2'b00, 4'b0000}));
        hsel = 1'b0; htrans = 2'b10;
        @(negedge clk);
        check("unselected ready", 32'({hreadyout, hresp, psel}), 32'({1'b1, 2'b00, 4'b0000}));
        hsel = 1'b1; hreadyin = 1'b0;
        @(negedge clk);
        check("hreadyin low ready", 32'({hreadyout, psel}), 32'({1'b1, 4'b0000}));
        hsel = 1'b0; htrans = 2'b00; hreadyin = 1'b1;

        // OKAY transfers chain back-to-back: each starts in the cycle HREADYout returns high.
        for (int k = 0; k < 13; k++) run_xfer(k, tbl[k]);

        // Slave0 never ready: TIMEOUT=8 instance errors, TIMEOUT=0 instance keeps waiting.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        low = 0; pcyc = 0; got = 0; resp = 2'b00;
        for (int c = 0; c < 30; c++) begin
            if (!got) begin
                if (hreadyout) begin
                    got = 1; resp = hresp;
                end else begin
                    low++;
                end
            end
            if (psel != 4'b0000) pcyc++;
            @(negedge clk);
        end
        check("timeout seen", 32'(got), 1);
        check("timeout hresp", 32'(resp), 1);
        check("timeout low cycles", low, 11);
        check("timeout psel cycles", pcyc, 9);
        check("no-timeout psel", 32'(psel_z), 32'h1);
        check("no-timeout penable", 32'(penable_z), 1);
        check("no-timeout hreadyout", 32'(hreadyout_z), 0);

        // Reset in ACCESS abandons the transfer.
        hreset = 1'b1;
        @(negedge clk);
        check("midrst psel", 32'(psel_z), 0);
        check("midrst penable", 32'(penable_z), 0);
        check("midrst hreadyout", 32'(hreadyout_z), 1);
        check("midrst hresp", 32'(hresp_z), 0);
        check("midrst hrdata", hrdata_z, 0);
        hreset = 1'b0;
        @(negedge clk);
        fin = '{1'b0, 32'h0000_3004, 3'd2, 32'h0, 32'h600D_CAFE, 1, 1'b0, 2'b00, 4, 4'b1000, 3,
                4'b0000, 32'h600D_CAFE};
        run_xfer(20, fin);
        check("post-rst hrdata z", hrdata_z, 32'h600D_CAFE);
        check("post-rst psel z", 32'(psel_z), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
